// File: rtl/controlador_de_status_if.sv
// ---------------------------------------------------------------------------
// controlador_de_status_if
// Groups the request inputs and status outputs of controlador_de_status.
//   i_ligar      power request (1 = on)
//   i_disparar   fire request, level-sampled every cycle
//   i_abortar    cancels an attack in progress
//   o_a, o_b     status bits for the external status decoder
//   o_armado     preparation complete, ready to fire
//   o_restante   cycles left in the current timed state, else 0
//   o_disparos   completed-attack count, saturating at 15
// master: the side issuing requests; slave: the controller itself.
// ---------------------------------------------------------------------------
interface controlador_de_status_if;
    logic       i_ligar;
    logic       i_disparar;
    logic       i_abortar;
    logic       o_a;
    logic       o_b;
    logic       o_armado;
    logic [7:0] o_restante;
    logic [3:0] o_disparos;

    modport master (
        output i_ligar, i_disparar, i_abortar,
        input  o_a, o_b, o_armado, o_restante, o_disparos
    );

    modport slave (
        input  i_ligar, i_disparar, i_abortar,
        output o_a, o_b, o_armado, o_restante, o_disparos
    );
endinterface

// File: rtl/controlador_de_status.sv
// ---------------------------------------------------------------------------
// controlador_de_status
// Power / preparation / armed / attack status controller.
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    controlador_de_status_if.slave (requests in, status out)
// Parameters:
//   PREP_CICLOS    length of PREPARACAO in cycles (1..255)
//   ATAQUE_CICLOS  length of ATAQUE in cycles (1..255)
// All outputs come from registers or are decoded from the registered state.
// ---------------------------------------------------------------------------
module controlador_de_status #(
    parameter int PREP_CICLOS   = 8,
    parameter int ATAQUE_CICLOS = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    controlador_de_status_if.slave       bus
);

    typedef enum logic [1:0] {
        DESLIGADO  = 2'd0,
        PREPARACAO = 2'd1,
        ARMADO     = 2'd2,
        ATAQUE     = 2'd3
    } estado_t;

    localparam logic [7:0] PREP_CARGA   = 8'(PREP_CICLOS - 1);
    localparam logic [7:0] ATAQUE_CARGA = 8'(ATAQUE_CICLOS - 1);

    estado_t    r_estado;
    logic [7:0] r_restante;
    logic [3:0] r_disparos;

    // Priority: power off, then abort, then timer expiry, then fire.
    // A timed state ends on the cycle whose remaining count is 0, so a
    // load of N-1 gives exactly N cycles, including N = 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado   <= DESLIGADO;
            r_restante <= 8'd0;
            r_disparos <= 4'd0;
        end else if (!bus.i_ligar) begin
            r_estado   <= DESLIGADO;
            r_restante <= 8'd0;
            r_disparos <= 4'd0;
        end else begin
            case (r_estado)
                DESLIGADO: begin
                    r_estado   <= PREPARACAO;
                    r_restante <= PREP_CARGA;
                end
                PREPARACAO: begin
                    if (r_restante == 8'd0) begin
                        r_estado   <= ARMADO;
                    end else begin
                        r_restante <= r_restante - 8'd1;
                    end
                end
                ARMADO: begin
                    if (bus.i_disparar) begin
                        r_estado   <= ATAQUE;
                        r_restante <= ATAQUE_CARGA;
                    end
                end
                ATAQUE: begin
                    if (bus.i_abortar) begin
                        r_estado   <= PREPARACAO;
                        r_restante <= PREP_CARGA;
                    end else if (r_restante == 8'd0) begin
                        // Always recharge after an attack, even with disparar held.
                        r_estado   <= PREPARACAO;
                        r_restante <= PREP_CARGA;
                        if (r_disparos != 4'd15) begin
                            r_disparos <= r_disparos + 4'd1;
                        end
                    end else begin
                        r_restante <= r_restante - 8'd1;
                    end
                end
                default: begin
                    r_estado   <= DESLIGADO;
                    r_restante <= 8'd0;
                end
            endcase
        end
    end

    // Status code 01 is unreachable: B implies A by construction.
    assign bus.o_a        = (r_estado != DESLIGADO);
    assign bus.o_b        = (r_estado == ATAQUE);
    assign bus.o_armado   = (r_estado == ARMADO);
    assign bus.o_restante = r_restante;
    assign bus.o_disparos = r_disparos;

endmodule

// File: doc/controlador_de_status.md
CONTROLADOR_DE_STATUS -- requirements
Module: controlador_de_status

Interface
REQ-001 Parameter PREP_CICLOS, default 8: length of PREPARACAO in clock cycles (legal range 1..255).
REQ-002 Parameter ATAQUE_CICLOS, default 4: length of ATAQUE in clock cycles (legal range 1..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ligar  input  1  power request; 1 = system on, 0 = system off.
REQ-006 disparar  input  1  fire request, level-sampled each cycle.
REQ-007 abortar  input  1  cancels an attack in progress.
REQ-008 A  output  1  status bit A, drives the status decoder.
REQ-009 B  output  1  status bit B, drives the status decoder.
REQ-010 armado  output  1  preparation complete, ready to fire.
REQ-011 restante  output  8  cycles remaining in the current timed state, else 0.
REQ-012 disparos  output  4  completed-attack count, saturating.

Function
REQ-013 The block SHALL use four internal states: DESLIGADO, PREPARACAO, ARMADO and ATAQUE.
REQ-014 The block SHALL drive {A,B} as 00 in DESLIGADO, 10 in PREPARACAO and ARMADO, and 11 in ATAQUE; 01 SHALL never be driven.
REQ-015 The block SHALL assert armado=1 only in ARMADO.
REQ-016 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.
REQ-017 Transition priority SHALL be ligar=0, then abortar, then timer expiry, then disparar.
REQ-018 In any state other than DESLIGADO, ligar=0 SHALL move the block to DESLIGADO on the next edge.
REQ-019 In DESLIGADO, ligar=1 SHALL move the block to PREPARACAO with restante loaded to PREP_CICLOS-1.
REQ-020 In PREPARACAO, restante SHALL decrement by 1 per cycle.
REQ-021 In PREPARACAO, the cycle with restante=0 SHALL be followed by ARMADO, so PREPARACAO lasts exactly PREP_CICLOS cycles.
REQ-022 In PREPARACAO, disparar SHALL be ignored and SHALL NOT be remembered.
REQ-023 In ARMADO, restante SHALL be 0, and disparar=1 SHALL move the block to ATAQUE with restante loaded to ATAQUE_CICLOS-1.
REQ-024 In ATAQUE, restante SHALL decrement by 1 per cycle.
REQ-025 In ATAQUE, the cycle with restante=0 SHALL be followed by PREPARACAO (recharge), with restante reloaded to PREP_CICLOS-1.
REQ-026 On that normal ATAQUE completion, disparos SHALL increment, saturating at 15.
REQ-027 In ATAQUE, abortar=1 (with ligar=1) SHALL move the block to PREPARACAO on the next edge, reload restante to PREP_CICLOS-1, and leave disparos unchanged.
REQ-028 abortar SHALL have no effect outside ATAQUE.
REQ-029 abortar=1 coinciding with ATAQUE expiry SHALL be treated as an abort, with no increment.
REQ-030 disparar held high through the end of an attack SHALL NOT skip the recharge; a new attack SHALL require returning to ARMADO.
REQ-031 Entering DESLIGADO SHALL clear restante and disparos to 0 on the same edge.
REQ-032 If PREP_CICLOS=1 or ATAQUE_CICLOS=1, the corresponding state SHALL last exactly one cycle.

Reset
REQ-033 rst_n=0 SHALL immediately, without waiting for clk, force state DESLIGADO, A=0, B=0, armado=0, restante=0 and disparos=0.
REQ-034 The block SHALL hold the values of REQ-033 while rst_n=0.
REQ-035 After rst_n rises, the first state change SHALL occur on a clk rising edge.
REQ-036 rst_n asserted mid-PREPARACAO or mid-ATAQUE SHALL abandon the timed state with no residual count.

Verification
REQ-037 Scenario 1, defaults, ligar 0->1 -> {A,B}=10 for exactly 8 cycles with restante 7..0, then armado=1.
REQ-038 Scenario 2, ARMADO with a 1-cycle disparar pulse -> {A,B}=11 for exactly 4 cycles, then PREPARACAO for 8 cycles, disparos=1.
REQ-039 Scenario 3, abortar=1 on the 2nd ATAQUE cycle -> next cycle {A,B}=10 with restante=7 and disparos unchanged; the same check repeated with abortar=1 on the final ATAQUE cycle (coinciding with expiry) -> no increment.
REQ-040 Scenario 4, ligar=0 during ATAQUE with abortar=1 -> next cycle {A,B}=00, restante=0, disparos=0.
REQ-041 Scenario 5, disparar held high continuously for 17 attacks -> disparos saturates at 15 and the block returns to PREPARACAO after every attack.
REQ-042 Scenario 6, rst_n pulsed low between clock edges mid-ATAQUE -> all outputs reach reset values before the next edge, and {A,B}=01 is never observed throughout.
